tx_lane_ctrl: RTL and testbench

Byte-clock-domain lane sequencer in front of TX_HS_FSM on the D-PHY transmit side. It accepts PPI-style HS requests from the protocol layer and drives the LP line states for HS entry (LP-11 → LP-01 → LP-00). It then enables TX_HS_FSM and streams bytes into it under a valid/ready handshake. On release it issues the end-of-data pulse, waits for the HS FSM to return idle, and holds LP-11 for the exit time before accepting a new burst.

---
 rtl/tx_dphy_pkg.sv | 46 ++++
 rtl/tx_lane_ctrl_if.sv | 35 +++
 rtl/tx_lane_timer.sv | 28 ++
 rtl/tx_lane_ctrl.sv | 169 ++++++++++++++++
 tb/tb_tx_lane_ctrl.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/tx_dphy_pkg.sv
// Shared D-PHY transmit definitions: lane controller states, TX_HS_FSM state
// encodings and LP line-state codes.
package tx_dphy_pkg;

  // Controller state encodings are exposed on Ctrl_State and must stay fixed.
  localparam logic [2:0] CTRL_STOP_ENC       = 3'd0;
  localparam logic [2:0] CTRL_HS_RQST_ENC    = 3'd1;
  localparam logic [2:0] CTRL_HS_PREPARE_ENC = 3'd2;
  localparam logic [2:0] CTRL_HS_ACTIVE_ENC  = 3'd3;
  localparam logic [2:0] CTRL_HS_END_ENC     = 3'd4;
  localparam logic [2:0] CTRL_HS_EXIT_ENC    = 3'd5;

  typedef enum logic [2:0] {
    ST_STOP       = CTRL_STOP_ENC,
    ST_HS_RQST    = CTRL_HS_RQST_ENC,
    ST_HS_PREPARE = CTRL_HS_PREPARE_ENC,
    ST_HS_ACTIVE  = CTRL_HS_ACTIVE_ENC,
    ST_HS_END     = CTRL_HS_END_ENC,
    ST_HS_EXIT    = CTRL_HS_EXIT_ENC
  } ctrl_state_t;

  // TX_HS_FSM state encodings as reported on TX_HS_STATE.
  localparam logic [2:0] HS_STATE_IDLE  = 3'd0;
  localparam logic [2:0] HS_STATE_SOT   = 3'd1;
  localparam logic [2:0] HS_STATE_DATA  = 3'd2;
  localparam logic [2:0] HS_STATE_TRAIL = 3'd3;
  localparam logic [2:0] HS_STATE_EOT   = 3'd4;
  localparam logic [2:0] HS_STATE_EXIT  = 3'd5;

  // LP line states as {Dp, Dn}.
  localparam logic [1:0] LP11 = 2'b11;
  localparam logic [1:0] LP01 = 2'b01;
  localparam logic [1:0] LP00 = 2'b00;

  function automatic logic [1:0] lp_for_state(input ctrl_state_t st);
    logic [1:0] lp;
    lp = LP11;
    case (st)
      ST_HS_RQST:                              lp = LP01;
      ST_HS_PREPARE, ST_HS_ACTIVE, ST_HS_END:  lp = LP00;
      default:                                 lp = LP11;
    endcase
    return lp;
  endfunction

endpackage

// File: rtl/tx_lane_ctrl_if.sv
// Bundle between the protocol layer / TX_HS_FSM side and the lane controller.
interface tx_lane_ctrl_if;

  // PPI side
  logic       TxRequestHS;
  logic [7:0] TxDataHS;
  logic       TxReadyHS;

  // TX_HS_FSM side
  logic       TX_HS_READY;
  logic [2:0] TX_HS_STATE;
  logic       HS_Enable;
  logic [7:0] TX_BYTE_DATA;
  logic       TX_HS_END_DATA;

  // LP driver and status
  logic       LP_DP;
  logic       LP_DN;
  logic       Lane_Busy;
  logic       Err_Timeout;
  logic [2:0] Ctrl_State;

  modport slave (
    input  TxRequestHS, TxDataHS, TX_HS_READY, TX_HS_STATE,
    output TxReadyHS, HS_Enable, TX_BYTE_DATA, TX_HS_END_DATA,
           LP_DP, LP_DN, Lane_Busy, Err_Timeout, Ctrl_State
  );

  modport master (
    output TxRequestHS, TxDataHS, TX_HS_READY, TX_HS_STATE,
    input  TxReadyHS, HS_Enable, TX_BYTE_DATA, TX_HS_END_DATA,
           LP_DP, LP_DN, Lane_Busy, Err_Timeout, Ctrl_State
  );

endinterface

// File: rtl/tx_lane_timer.sv
// Loadable down-counter shared by the timed lane states and the HS_END timeout.
module tx_lane_timer #(
  parameter int CNT_W = 8
) (
  input  logic             TX_DDR_clk,
  input  logic             TX_rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count_reg;

  // Load wins over decrement; the count saturates at zero.
  always_ff @(posedge TX_DDR_clk or negedge TX_rst_n) begin
    if (!TX_rst_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/tx_lane_ctrl.sv
// D-PHY transmit lane sequencer: LP-11 -> LP-01 -> LP-00 HS entry, byte
// streaming into TX_HS_FSM, end-of-data handshake and LP-11 exit hold.
module tx_lane_ctrl
  import tx_dphy_pkg::*;
#(
  parameter int T_LPX        = 4,
  parameter int T_HS_PREPARE = 3,
  parameter int T_HS_EXIT    = 8,
  parameter int END_TIMEOUT  = 32,
  parameter int CNT_W        = 8
) (
  input  logic           TX_DDR_clk,
  input  logic           TX_rst_n,
  tx_lane_ctrl_if.slave  lane
);

  // Timers are loaded with T-1 so each timed state lasts exactly T cycles.
  localparam logic [CNT_W-1:0] LPX_LOAD     = CNT_W'(T_LPX - 1);
  localparam logic [CNT_W-1:0] PREPARE_LOAD = CNT_W'(T_HS_PREPARE - 1);
  localparam logic [CNT_W-1:0] EXIT_LOAD    = CNT_W'(T_HS_EXIT - 1);
  localparam logic [CNT_W-1:0] END_LOAD     = CNT_W'(END_TIMEOUT - 1);

  ctrl_state_t      state_reg, state_next;
  logic             hs_enable_reg, hs_enable_next;
  logic [7:0]       byte_reg, byte_next;
  logic             end_pulse_reg, end_pulse_next;
  logic [1:0]       lp_reg, lp_next;
  logic             busy_reg, busy_next;
  logic             err_reg, err_next;

  logic             timer_load;
  logic [CNT_W-1:0] timer_val;
  logic             timer_dec;
  logic             timer_zero;

  logic             req;
  logic             tx_ready;
  logic             hs_idle;

  assign req      = lane.TxRequestHS;
  assign hs_idle  = (lane.TX_HS_STATE == HS_STATE_IDLE);
  assign tx_ready = (state_reg == ST_HS_ACTIVE) && lane.TX_HS_READY && req;

  tx_lane_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .TX_DDR_clk (TX_DDR_clk),
    .TX_rst_n   (TX_rst_n),
    .load       (timer_load),
    .load_val   (timer_val),
    .dec        (timer_dec),
    .zero       (timer_zero)
  );

  always_ff @(posedge TX_DDR_clk or negedge TX_rst_n) begin
    if (!TX_rst_n) begin
      state_reg     <= ST_STOP;
      hs_enable_reg <= 1'b0;
      byte_reg      <= 8'h00;
      end_pulse_reg <= 1'b0;
      lp_reg        <= LP11;
      busy_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      hs_enable_reg <= hs_enable_next;
      byte_reg      <= byte_next;
      end_pulse_reg <= end_pulse_next;
      lp_reg        <= lp_next;
      busy_reg      <= busy_next;
      err_reg       <= err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    hs_enable_next = 1'b0;
    byte_next      = byte_reg;
    end_pulse_next = 1'b0;
    err_next       = err_reg;
    timer_load     = 1'b0;
    timer_val      = '0;
    timer_dec      = (state_reg != ST_STOP);

    case (state_reg)
      ST_STOP: begin
        if (req) begin
          state_next = ST_HS_RQST;
          timer_load = 1'b1;
          timer_val  = LPX_LOAD;
        end
      end

      ST_HS_RQST: begin
        if (!req) begin
          state_next = ST_HS_EXIT;
          timer_load = 1'b1;
          timer_val  = EXIT_LOAD;
        end else if (timer_zero) begin
          state_next = ST_HS_PREPARE;
          timer_load = 1'b1;
          timer_val  = PREPARE_LOAD;
        end
      end

      ST_HS_PREPARE: begin
        if (!req) begin
          state_next = ST_HS_EXIT;
          timer_load = 1'b1;
          timer_val  = EXIT_LOAD;
        end else if (timer_zero) begin
          state_next     = ST_HS_ACTIVE;
          hs_enable_next = 1'b1;
        end
      end

      // Enable stays up into the first HS_END cycle alongside the END pulse.
      ST_HS_ACTIVE: begin
        hs_enable_next = 1'b1;
        if (!req) begin
          state_next     = ST_HS_END;
          end_pulse_next = 1'b1;
          timer_load     = 1'b1;
          timer_val      = END_LOAD;
        end else if (tx_ready) begin
          byte_next = lane.TxDataHS;
        end
      end

      // end_pulse_reg marks the first HS_END cycle, where idle is not yet trusted.
      ST_HS_END: begin
        if (!end_pulse_reg && hs_idle) begin
          state_next = ST_HS_EXIT;
          timer_load = 1'b1;
          timer_val  = EXIT_LOAD;
        end else if (timer_zero) begin
          state_next = ST_HS_EXIT;
          err_next   = 1'b1;
          timer_load = 1'b1;
          timer_val  = EXIT_LOAD;
        end
      end

      ST_HS_EXIT: begin
        if (timer_zero) begin
          state_next = ST_STOP;
        end
      end

      default: begin
        state_next = ST_STOP;
      end
    endcase

    lp_next   = lp_for_state(state_next);
    busy_next = (state_next != ST_STOP);
  end

  assign lane.TxReadyHS      = tx_ready;
  assign lane.HS_Enable      = hs_enable_reg;
  assign lane.TX_BYTE_DATA   = byte_reg;
  assign lane.TX_HS_END_DATA = end_pulse_reg;
  assign lane.LP_DP          = lp_reg[1];
  assign lane.LP_DN          = lp_reg[0];
  assign lane.Lane_Busy      = busy_reg;
  assign lane.Err_Timeout    = err_reg;
  assign lane.Ctrl_State     = state_reg;

endmodule

// File: tb/tb_tx_lane_ctrl.sv
// Self-checking bench for tx_lane_ctrl: scoreboarded byte path plus lane
// sequencing, abort, timeout and async reset scenarios.
module tb_tx_lane_ctrl;
  import tx_dphy_pkg::*;

  logic TX_DDR_clk = 1'b0;
  logic TX_rst_n;

  tx_lane_ctrl_if lane ();

  tx_lane_ctrl #(
    .T_LPX        (4),
    .T_HS_PREPARE (3),
    .T_HS_EXIT    (8),
    .END_TIMEOUT  (32),
    .CNT_W        (8)
  ) dut (
    .TX_DDR_clk (TX_DDR_clk),
    .TX_rst_n   (TX_rst_n),
    .lane       (lane)
  );

  always #5 TX_DDR_clk = ~TX_DDR_clk;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] sb_q[$];
  logic [7:0] exp_byte = 8'h00;
  logic       exp_err  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge TX_DDR_clk);
    #2;
  endtask

  task automatic check_lane(input string tag, input logic [2:0] st, input logic [1:0] lp,
                            input logic en, input logic endp, input logic busy);
    check({tag, "_state"}, 32'(lane.Ctrl_State), 32'(st));
    check({tag, "_lp"},    32'({lane.LP_DP, lane.LP_DN}), 32'(lp));
    check({tag, "_en"},    32'(lane.HS_Enable), 32'(en));
    check({tag, "_end"},   32'(lane.TX_HS_END_DATA), 32'(endp));
    check({tag, "_busy"},  32'(lane.Lane_Busy), 32'(busy));
    check({tag, "_err"},   32'(lane.Err_Timeout), 32'(exp_err));
  endtask

  // From STOP: 4 cycles LP-01, 3 cycles LP-00, Enable on the 8th edge.
  task automatic enter_active();
    lane.TxRequestHS = 1'b1;
    lane.TX_HS_READY = 1'b1;
    lane.TX_HS_STATE = HS_STATE_SOT;
    for (int n = 1; n <= 8; n++) begin
      tick();
      if (n <= 4)      check_lane("rqst", ST_HS_RQST, LP01, 1'b0, 1'b0, 1'b1);
      else if (n <= 7) check_lane("prep", ST_HS_PREPARE, LP00, 1'b0, 1'b0, 1'b1);
      else             check_lane("act",  ST_HS_ACTIVE, LP00, 1'b1, 1'b0, 1'b1);
      if (n < 8) check("ready_pre", 32'(lane.TxReadyHS), 32'd0);
    end
    $display("burst entered active at %0t", $time);
  endtask

  task automatic xfer(input logic [7:0] d, input logic rdy);
    lane.TxDataHS    = d;
    lane.TX_HS_READY = rdy;
    #1;
    check("txready", 32'(lane.TxReadyHS), 32'(rdy));
    if (rdy) sb_q.push_back(d);
    tick();
    if (sb_q.size() > 0) exp_byte = sb_q.pop_front();
    check("byte", 32'(lane.TX_BYTE_DATA), 32'(exp_byte));
    check("en_act", 32'(lane.HS_Enable), 32'd1);
    $display("xfer data=%h rdy=%b byte_out=%h", d, rdy, lane.TX_BYTE_DATA);
  endtask

  task automatic exit_phase();
    for (int k = 1; k <= 8; k++) begin
      tick();
      check_lane("exit", ST_HS_EXIT, LP11, 1'b0, 1'b0, 1'b1);
      check("ready_exit", 32'(lane.TxReadyHS), 32'd0);
    end
    tick();
    check_lane("stop", ST_STOP, LP11, 1'b0, 1'b0, 1'b0);
    $display("lane back to STOP at %0t", $time);
  endtask

  // Drop request with new data and ready present: no byte may be taken.
  task automatic end_burst();
    lane.TxRequestHS = 1'b0;
    lane.TxDataHS    = 8'hEE;
    lane.TX_HS_READY = 1'b1;
    #1;
    check("ready_drop", 32'(lane.TxReadyHS), 32'd0);
    tick();
    check_lane("end1", ST_HS_END, LP00, 1'b1, 1'b1, 1'b1);
    check("byte_hold", 32'(lane.TX_BYTE_DATA), 32'(exp_byte));
    lane.TX_HS_STATE = HS_STATE_IDLE;
    tick();
    check_lane("end2", ST_HS_END, LP00, 1'b0, 1'b0, 1'b1);
    exit_phase();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    TX_rst_n         = 1'b0;
    lane.TxRequestHS = 1'b0;
    lane.TxDataHS    = 8'h00;
    lane.TX_HS_READY = 1'b0;
    lane.TX_HS_STATE = HS_STATE_IDLE;
    #12;
    check_lane("rst", ST_STOP, LP11, 1'b0, 1'b0, 1'b0);
    check("rst_byte", 32'(lane.TX_BYTE_DATA), 32'd0);
    #21 TX_rst_n = 1'b1;

    // Idle with no request.
    for (int i = 0; i < 10; i++) begin
      tick();
      check_lane("idle", ST_STOP, LP11, 1'b0, 1'b0, 1'b0);
      check("idle_byte", 32'(lane.TX_BYTE_DATA), 32'd0);
      check("idle_ready", 32'(lane.TxReadyHS), 32'd0);
    end

    // Basic burst.
    enter_active();
    xfer(8'hA5, 1'b1);
    xfer(8'h3C, 1'b1);
    xfer(8'hF0, 1'b1);
    end_burst();

    // Stall.
    enter_active();
    xfer(8'h11, 1'b1);
    xfer(8'h22, 1'b0);
    xfer(8'h22, 1'b0);
    xfer(8'h22, 1'b1);
    end_burst();

    // Abort during the second HS_PREPARE cycle.
    lane.TxRequestHS = 1'b1;
    lane.TX_HS_STATE = HS_STATE_SOT;
    for (int n = 1; n <= 6; n++) tick();
    check_lane("abort_prep", ST_HS_PREPARE, LP00, 1'b0, 1'b0, 1'b1);
    lane.TxRequestHS = 1'b0;
    exit_phase();
    $display("abort done");

    // End timeout: HS FSM never returns to idle.
    enter_active();
    xfer(8'h77, 1'b1);
    lane.TX_HS_STATE = HS_STATE_EXIT;
    lane.TxRequestHS = 1'b0;
    tick();
    check_lane("to_end1", ST_HS_END, LP00, 1'b1, 1'b1, 1'b1);
    for (int k = 2; k <= 32; k++) begin
      tick();
      check_lane("to_wait", ST_HS_END, LP00, 1'b0, 1'b0, 1'b1);
    end
    exp_err = 1'b1;
    exit_phase();
    $display("timeout burst done, Err_Timeout=%b", lane.Err_Timeout);

    // Clean burst: sticky error must survive.
    enter_active();
    xfer(8'h9C, 1'b1);
    end_burst();

    // Async reset mid-burst.
    enter_active();
    xfer(8'h5A, 1'b1);
    #1 TX_rst_n = 1'b0;
    #1;
    exp_err  = 1'b0;
    exp_byte = 8'h00;
    sb_q.delete();
    check_lane("arst", ST_STOP, LP11, 1'b0, 1'b0, 1'b0);
    check("arst_byte", 32'(lane.TX_BYTE_DATA), 32'd0);
    check("arst_ready", 32'(lane.TxReadyHS), 32'd0);
    lane.TxRequestHS = 1'b0;
    tick();
    TX_rst_n = 1'b1;
    tick();
    check_lane("post_rst", ST_STOP, LP11, 1'b0, 1'b0, 1'b0);
    $display("async reset done");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
